priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant is held (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4, per-requester request level where bit 3 is highest fixed priority.
REQ-005 The block SHALL have port gnt, output, 4, one-hot grant that is all-zero when no grant is active.
REQ-006 The block SHALL have port gnt_id, output, 2, binary index of the granted requester, or 2'b00 when idle.
REQ-007 The block SHALL have port busy, output, 1, high while any grant is active.
REQ-008 The block SHALL have port timeout, output, 1, a one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 The block SHALL implement the FSM states IDLE, GRANT and RELEASE, with all outputs driven directly from registers.
REQ-010 In IDLE with any eligible req bit high, the block SHALL select a winner and enter GRANT, with gnt, gnt_id and busy valid on the next rising edge (1-cycle request-to-grant latency).
REQ-011 A requester SHALL be eligible when its req bit is high and it is not masked per REQ-015.
REQ-012 The block SHALL hold gnt stable in GRANT, with no preemption by higher-priority requests.
REQ-013 The block SHALL keep an 8-bit hold_cnt that is cleared to 0 on entering GRANT and incremented once per GRANT cycle.
REQ-014 In GRANT, when req[gnt_id]=0 the block SHALL enter RELEASE, with gnt=0 and busy=0 on the next edge.
REQ-015 In GRANT, when hold_cnt=MAX_HOLD-1 and req[gnt_id]=1, the block SHALL enter RELEASE, pulse timeout for exactly that next cycle, and mask the revoked requester for the following single arbitration only.
REQ-016 If the owner drops req in the same cycle that hold_cnt=MAX_HOLD-1, the block SHALL treat it as a normal release, with no timeout and no mask.
REQ-017 RELEASE SHALL last exactly one cycle and then go to IDLE, giving a guaranteed one dead cycle between consecutive grants.
REQ-018 If the only request pending at the masked arbitration is the masked requester, the block SHALL stay in IDLE for that cycle, clear the mask, and let the requester win on the next arbitration.
REQ-019 A requester asserting and dropping req within one cycle while the FSM is not in IDLE SHALL be ignored, because requests are level-sampled only in IDLE.
REQ-020 gnt SHALL never have more than one bit set, and gnt SHALL be nonzero only in GRANT.

Reset
REQ-021 Asserting rst_n=0 SHALL take effect immediately regardless of clk, setting FSM=IDLE, gnt=4'b0000, gnt_id=2'b00, busy=0, timeout=0, hold_cnt=0, mask cleared and RR pointer=0.
REQ-022 Reset asserted mid-grant SHALL drop gnt within the same cycle, and arbitration SHALL restart from IDLE on the first rising edge after rst_n deasserts.

Configuration
REQ-023 When macro ARB_ROUND_ROBIN_EN is defined, the winner SHALL be the first eligible requester scanning upward from the RR pointer (index pointer, pointer+1, ... modulo 4), and the pointer SHALL update to (winner+1) mod 4 on each grant.
REQ-024 When ARB_ROUND_ROBIN_EN is undefined, the winner SHALL be the highest-index eligible requester (fixed priority 3>2>1>0), and no pointer register SHALL exist.

Verification
REQ-025 The bench SHALL check: reset, then req=4'b0101 held → gnt=4'b0100 and gnt_id=2 one cycle later; drop req[2] → RELEASE, then gnt=4'b0001 three cycles after the drop.
REQ-026 The bench SHALL check: MAX_HOLD=8, req=4'b1000 held → gnt=4'b1000 for exactly 8 cycles, a timeout pulse of 1 cycle, gnt=0 for 2 cycles, then gnt=4'b1000 again.
REQ-027 The bench SHALL check: fixed priority with req=4'b1010 and a timeout on requester 3 → the next grant is 4'b0010, then 4'b1000 after it.
REQ-028 The bench SHALL check (ARB_ROUND_ROBIN_EN): req=4'b1111 held with each owner dropping req after 2 cycles then reasserting → grant order 0,1,2,3,0.
REQ-029 The bench SHALL check: rst_n pulsed low mid-grant between clock edges → gnt=0 and busy=0 immediately, and the first grant one cycle after release of reset.
REQ-030 The bench SHALL check: owner drops req on the hold_cnt=MAX_HOLD-1 cycle → timeout stays 0 and no mask is applied.

Source files
------------

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - 4-requester grant arbiter with hold limit and timeout masking
//
// Purpose: grants one of four requesters at a time. A grant is held until the
// owner drops its request or until MAX_HOLD cycles have elapsed. A revoked owner
// is masked for the next arbitration. Every grant is followed by one dead
// (RELEASE) cycle.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - round-robin winner selection starting from a rotating pointer
//   undefined - fixed priority, requester 3 highest, no pointer register
//
// Parameters:
//   MAX_HOLD  - maximum consecutive cycles one grant is held (2..255)
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   req[3:0]  - request levels, sampled only while idle
//   gnt[3:0]  - one-hot grant, zero when no grant is active
//   gnt_id    - index of the granted requester, 0 when idle
//   busy      - high while a grant is active
//   timeout   - one-cycle pulse when a grant is revoked by the hold limit
module priority_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] mask_q, mask_d;

  logic [3:0] eligible;
  logic [1:0] win;

  assign eligible = req & ~mask_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;

  // Scan offsets from the far end down so the offset closest to the pointer
  // is the last one written and therefore wins.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (eligible[idx]) win = idx;
    end
  end
`else
  // Ascending scan: the highest eligible index is written last and wins.
  always_comb begin
    win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i]) win = 2'(i);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // The mask covers exactly one arbitration, whether or not anyone wins it.
        mask_d = 4'b0000;
        if (|eligible) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << win;
          gnt_id_d   = win;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d      = win + 2'd1;
`endif
        end
      end
      GRANT: begin
        // A voluntary drop takes precedence over the hold limit.
        if (!req[gnt_id_q]) begin
          state_d  = RELEASE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          busy_d   = 1'b0;
        end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
          state_d   = RELEASE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          mask_d    = gnt_q;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      mask_q     <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - self-checking bench for priority_arbiter
module tb_priority_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  priority_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the grant, how many cycles it has been held,
  // whether we are in the dead cycle, and who (if anyone) is barred next time.
  int m_owner;
  int m_held;
  bit m_dead;
  bit m_timeout;
  int m_mask;
  int m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_dead    = 1'b0;
    m_timeout = 1'b0;
    m_mask    = -1;
    m_ptr     = 0;
  endtask

  function automatic int pick(input logic [3:0] r);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 3; k >= 0; k--) begin
      if (r[(m_ptr + k) % 4] && ((m_ptr + k) % 4 != m_mask)) w = (m_ptr + k) % 4;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (r[i] && i != m_mask) w = i;
    end
`endif
    return w;
  endfunction

  task automatic model_update();
    int w;
    m_timeout = 1'b0;
    if (m_dead) begin
      m_dead = 1'b0;
    end else if (m_owner < 0) begin
      w = pick(req);
      m_mask = -1;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_ptr   = (w + 1) % 4;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_dead  = 1'b1;
    end else if (m_held == MAX_HOLD) begin
      m_mask    = m_owner;
      m_owner   = -1;
      m_dead    = 1'b1;
      m_timeout = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    logic [3:0] eg;
    @(posedge clk);
    model_update();
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_idle();
    req = 4'b0000;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   got_id;
    bit   found;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Two requesters; drop the winner and watch the other take over.
    req = 4'b0101;
    step();
`ifndef ARB_ROUND_ROBIN_EN
    check("a_first_gnt", 32'(gnt), 32'h4);
    check("a_first_id", 32'(gnt_id), 32'd2);
`endif
    repeat (2) step();
    req = 4'b0001;
    step();
    check("a_release_gnt", 32'(gnt), 32'd0);
    step();
    step();
`ifndef ARB_ROUND_ROBIN_EN
    check("a_second_gnt", 32'(gnt), 32'h1);
`endif
    go_idle();

    // Lone requester held past the limit: 8 grant cycles, timeout cycle,
    // masked idle cycle, plain idle cycle, then the grant returns.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      step();
      check("b_hold_gnt", 32'(gnt), 32'h8);
    end
    step();
    check("b_timeout", 32'(timeout), 32'd1);
    check("b_to_gnt", 32'(gnt), 32'd0);
    step();
    check("b_idle1_gnt", 32'(gnt), 32'd0);
    check("b_idle1_to", 32'(timeout), 32'd0);
    step();
    check("b_idle2_gnt", 32'(gnt), 32'd0);
    step();
    check("b_regrant", 32'(gnt), 32'h8);
    go_idle();

    // Timeout on requester 3 with requester 1 also waiting.
    req = 4'b1010;
    repeat (MAX_HOLD) step();
    step();
    check("c_timeout", 32'(timeout), 32'd1);
    step();
    step();
`ifndef ARB_ROUND_ROBIN_EN
    check("c_next_gnt", 32'(gnt), 32'h2);
`endif
    step();
    req = 4'b1000;
    repeat (3) step();
`ifndef ARB_ROUND_ROBIN_EN
    check("c_after_gnt", 32'(gnt), 32'h8);
`endif
    go_idle();

    // All four requesting, each owner leaves after two grant cycles.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        step();
        if (busy) found = 1'b1;
      end
      check("d_grant_seen", 32'(found), 32'd1);
      got_id = int'(gnt_id);
`ifdef ARB_ROUND_ROBIN_EN
      check("d_rr_order", 32'(got_id), 32'(g % 4));
`else
      check("d_fixed_order", 32'(got_id), 32'd3);
`endif
      step();
      req[got_id] = 1'b0;
      step();
      req = 4'b1111;
    end
    go_idle();

    // Asynchronous reset between clock edges while a grant is held.
    req = 4'b0010;
    step();
    step();
    check("e_pre_gnt", 32'(gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("e_async_gnt", 32'(gnt), 32'd0);
    check("e_async_busy", 32'(busy), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    step();
    check("e_first_gnt", 32'(gnt), 32'h2);
    go_idle();

    // Owner drops exactly on the last allowed cycle: plain release, no mask.
    req = 4'b0100;
    repeat (MAX_HOLD) step();
    check("f_last_cycle_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    check("f_no_timeout", 32'(timeout), 32'd0);
    req = 4'b0100;
    step();
    step();
    check("f_no_mask_gnt", 32'(gnt), 32'h4);
    go_idle();

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
